serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first, as a + ~b + 1 through a single one-bit full-adder cell. It is the inverse-operation companion to the parallel 4-bit adder, and trades latency for one adder cell. A start/busy/done handshake lets a controller FSM issue operations and collect results.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor_fa.sv | 11 +
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow helper used when a result is committed.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } sub_state_e;

    // Signed overflow of a - b: only possible when the operand signs differ,
    // and flagged when the result sign disagrees with the minuend sign.
    function automatic logic sub_overflow(input logic a_sign,
                                          input logic b_sign,
                                          input logic d_sign);
        return (a_sign != b_sign) && (d_sign != a_sign);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a controller and the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             carryout;
    logic             overflow;

    // Controller side: issues operands, collects results.
    modport master (
        output start, a, b,
        input  busy, done, difference, carryout, overflow
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, difference, carryout, overflow
    );
endinterface

// File: rtl/serial_subtractor_fa.sv
// One-bit full-adder cell: the only arithmetic element of the serial datapath.
module serial_subtractor_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ carry_i;
    assign carry_o = (a_i & b_i) | (a_i & carry_i) | (b_i & carry_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed as a + ~b + 1, one
// bit per clock LSB first, through a single full-adder cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sub_state_e       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             a_sign_q;
    logic             b_sign_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             carryout_q;
    logic             overflow_q;

    logic             sum_s;
    logic             carry_s;
    logic [WIDTH-1:0] res_d;

    // The subtrahend bit is inverted on its way into the cell; the +1 comes
    // from seeding the carry register with 1 on acceptance.
    serial_subtractor_fa u_fa (
        .a_i     (a_sh_q[0]),
        .b_i     (~b_sh_q[0]),
        .carry_i (carry_q),
        .sum_o   (sum_s),
        .carry_o (carry_s)
    );

    // Result register fills from the MSB side so the final bit lands on top.
    assign res_d = {sum_s, res_q[WIDTH-1:1]};

    // Control FSM, shift datapath and registered result outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= {WIDTH{1'b0}};
            b_sh_q     <= {WIDTH{1'b0}};
            res_q      <= {WIDTH{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            carry_q    <= 1'b0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= {WIDTH{1'b0}};
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Operands are captured only here; later changes are ignored.
                        a_sh_q   <= bus.a;
                        b_sh_q   <= bus.b;
                        a_sign_q <= bus.a[WIDTH-1];
                        b_sign_q <= bus.b[WIDTH-1];
                        res_q    <= {WIDTH{1'b0}};
                        carry_q  <= 1'b1;
                        count_q  <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry_q <= carry_s;
                    res_q   <= res_d;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    if (count_q == LAST_CNT) begin
                        // Last bit: commit the whole result in the same edge that raises done.
                        count_q    <= {CNT_W{1'b0}};
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        diff_q     <= res_d;
                        carryout_q <= carry_s;
                        overflow_q <= sub_overflow(a_sign_q, b_sign_q, sum_s);
                    end else begin
                        count_q    <= count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.difference = diff_q;
    assign bus.carryout   = carryout_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of the 4-bit serial subtractor.
module tb_serial_subtractor;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   start_cnt;
    int   done_cnt;

    serial_subtractor_if #(.WIDTH(4)) bus ();

    serial_subtractor #(.WIDTH(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;

    // Count done pulses for the start/done balance check.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request now; it is taken on the next rising edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        start_cnt++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; returns edges since acceptance and busy-high samples.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done !== 1'b1 && bus.busy === 1'b1) busy_n++;
        end
        if (lat >= 20) chk("done_timeout", 32'(lat), 32'd4);
    endtask

    task automatic check_res(input string tag, input logic [3:0] d, input logic co, input logic ov);
        chk({tag, "_diff"}, 32'(bus.difference), 32'(d));
        chk({tag, "_co"},   32'(bus.carryout),   32'(co));
        chk({tag, "_ov"},   32'(bus.overflow),   32'(ov));
    endtask

    task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic co, input logic ov);
        int lat, bn;
        issue(a, b);
        wait_done(lat, bn);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        check_res(tag, d, co, ov);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[5] = '{
        '{4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0},
        '{4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0},
        '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0},
        '{4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1},
        '{4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1}
    };

    initial begin
        int lat, bn;
        logic [3:0] ed;
        logic [4:0] sum5;
        logic       eov;
        n_vec = 0; n_miss = 0; start_cnt = 0; done_cnt = 0;
        bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", 4'd0, 1'b0, 1'b0);

        // First op with busy-duration and hold checks.
        issue(4'b0101, 4'b0011);
        wait_done(lat, bn);
        chk("first_lat", 32'(lat), 32'd4);
        chk("first_busy_cycles", 32'(bn), 32'd4);
        chk("first_busy_at_done", 32'(bus.busy), 32'd0);
        check_res("first", 4'b0010, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        check_res("hold", 4'b0010, 1'b1, 1'b0);

        foreach (vecs[i]) op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].co, vecs[i].ov);
        @(posedge clk); #1;

        // Start and operand changes during RUN are ignored; result held meanwhile.
        issue(4'b0101, 4'b0011);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b1111;
        @(posedge clk); #1;
        chk("run_hold_diff", 32'(bus.difference), 32'(4'b0111));
        bus.start = 1'b0; bus.a = 4'b1010; bus.b = 4'b0110;
        wait_done(lat, bn);
        chk("ignore_lat", 32'(lat), 32'd2);
        check_res("ignore", 4'b0010, 1'b1, 1'b0);

        // Back-to-back issue in the DONE cycle.
        issue(4'b0011, 4'b0101);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_hold_diff", 32'(bus.difference), 32'(4'b0010));
        wait_done(lat, bn);
        chk("b2b_lat", 32'(lat), 32'd4);
        check_res("b2b", 4'b1110, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset on the second RUN cycle abandons the operation.
        issue(4'b0101, 4'b0011);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        check_res("abort", 4'd0, 1'b0, 1'b0);
        done_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        op("after_abort", 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);

        // Exhaustive sweep against an arithmetic reference.
        @(posedge clk); #1;
        start_cnt = 0; done_cnt = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ed   = 4'(ia - ib);
                sum5 = 5'(ia) + 5'({1'b0, ~4'(ib)}) + 5'd1;
                eov  = ((ia >= 8) != (ib >= 8)) && (ed[3] != (ia >= 8));
                op($sformatf("sw_%0h_%0h", ia, ib), 4'(ia), 4'(ib), ed, sum5[4], eov);
            end
        end
        @(posedge clk); #1;
        chk("done_vs_start", 32'(done_cnt), 32'(start_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
